// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and memory map for the 2x2 matrix unit sequencer
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_e;

    localparam int MEM_DEPTH   = 8;
    localparam int NUM_WEIGHTS = 4;
    localparam int NUM_RESULTS = 4;
    localparam int WEIGHT_BASE = 0;
    localparam int MAT_BASE    = 4;

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int OUT_W  = $clog2(NUM_RESULTS);

    // Load starts at the first weight and ends on the last matrix entry (matrix is as large as the weight set).
    localparam logic [ADDR_W-1:0] LOAD_FIRST = ADDR_W'(WEIGHT_BASE);
    localparam logic [ADDR_W-1:0] LOAD_LAST  = ADDR_W'(MAT_BASE + NUM_WEIGHTS - 1);
    localparam logic [OUT_W-1:0]  OUT_LAST   = OUT_W'(NUM_RESULTS - 1);

    function automatic int phase_width(input int compute_cycles, input int settle_cycles);
        int longest;
        longest = (compute_cycles > settle_cycles) ? compute_cycles : settle_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/tpu_sequencer_if.sv
// rtl/tpu_sequencer_if.sv - host stream, memory write, array control and result signals of the sequencer
interface tpu_sequencer_if;
    import tpu_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wm_load_mat;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wm_data;
    logic              mmu_clear;
    logic              mmu_en;
    logic [OUT_W-1:0]  res_sel;
    logic [7:0]        res_data;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  in_valid, in_data, res_data, out_ready,
        output in_ready, wm_load_mat, addr, wm_data, mmu_clear, mmu_en,
               res_sel, out_valid, out_data, busy, done
    );

    modport master (
        output in_valid, in_data, res_data, out_ready,
        input  in_ready, wm_load_mat, addr, wm_data, mmu_clear, mmu_en,
               res_sel, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/tpu_sequencer.sv
// rtl/tpu_sequencer.sv - load 8 bytes, settle, run the array, stream 4 results back
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 5,
    parameter int SETTLE_CYCLES  = 2
) (
    input logic            clk,
    input logic            rst,
    tpu_sequencer_if.slave bus
);

    localparam int PW = phase_width(COMPUTE_CYCLES, SETTLE_CYCLES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= LOAD_FIRST;
            out_cnt_q  <= '0;
            phase_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            out_cnt_q  <= out_cnt_d;
            phase_q    <= phase_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        load_cnt_d      = load_cnt_q;
        out_cnt_d       = out_cnt_q;
        phase_d         = phase_q;
        done_d          = 1'b0;
        bus.in_ready    = 1'b0;
        bus.wm_load_mat = 1'b0;
        bus.mmu_clear   = 1'b0;
        bus.mmu_en      = 1'b0;
        bus.out_valid   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                bus.in_ready    = 1'b1;
                bus.wm_load_mat = bus.in_valid;
                if (bus.in_valid) begin
                    if (load_cnt_q == LOAD_LAST) begin
                        load_cnt_d = LOAD_FIRST;
                        phase_d    = '0;
                        state_d    = ST_SETTLE;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                // Accumulators are cleared while memory output registers catch up with the last write.
                bus.mmu_clear = (phase_q == '0);
                if (phase_q == PW'(SETTLE_CYCLES - 1)) begin
                    phase_d = '0;
                    state_d = ST_COMPUTE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_COMPUTE: begin
                bus.mmu_en = 1'b1;
                if (phase_q == PW'(COMPUTE_CYCLES - 1)) begin
                    phase_d   = '0;
                    out_cnt_d = '0;
                    state_d   = ST_OUTPUT;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (out_cnt_q == OUT_LAST) begin
                        out_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign bus.addr     = load_cnt_q;
    assign bus.wm_data  = bus.in_data;
    assign bus.res_sel  = out_cnt_q;
    assign bus.out_data = bus.res_data;
    assign bus.busy     = (state_q != ST_LOAD);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// tb/tb_tpu_sequencer.sv - randomized job-level checks of the matrix unit sequencer
module tb_tpu_sequencer;

    localparam int S = 2;
    localparam int C = 5;

    logic       clk;
    logic       rst;
    logic [7:0] res_base;
    logic [7:0] mem_dut   [8];
    logic [7:0] mem_model [8];
    int         n_checks;
    int         n_fail;

    tpu_sequencer_if bus();

    tpu_sequencer #(.COMPUTE_CYCLES(C), .SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Result mux stand-in: each result index returns a distinct byte.
    assign bus.res_data = res_base + 8'(bus.res_sel);

    // Memory stand-in that records every write the sequencer issues.
    always @(posedge clk) begin
        if (bus.wm_load_mat) mem_dut[bus.addr] <= bus.wm_data;
    end

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        bus.in_data = 8'($urandom);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.wm_load_mat, bus.addr, bus.mmu_clear, bus.mmu_en, bus.res_sel,
             bus.out_valid, bus.busy, bus.done} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL reset_ctrl: got %b", {bus.in_ready, bus.wm_load_mat, bus.addr,
                bus.mmu_clear, bus.mmu_en, bus.res_sel, bus.out_valid, bus.busy, bus.done}); end
        n_checks++;
        if ({bus.wm_data, bus.out_data} !== {bus.in_data, res_base})
            begin n_fail++; $display("FAIL reset_data: got %h/%h expected %h/%h",
                bus.wm_data, bus.out_data, bus.in_data, res_base); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_job(input logic [7:0] b [8], input int gap_lo, input int gap_hi);
        for (int k = 0; k < 8; k++) begin
            int gap;
            gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                #1;
                n_checks++;
                if ({bus.in_ready, bus.wm_load_mat, bus.addr, bus.busy} !== {1'b1, 1'b0, 3'(k), 1'b0})
                    begin n_fail++; $display("FAIL load_idle[%0d]: got %b expected %b", k,
                        {bus.in_ready, bus.wm_load_mat, bus.addr, bus.busy}, {1'b1, 1'b0, 3'(k), 1'b0}); end
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b[k];
            #1;
            n_checks++;
            if ({bus.in_ready, bus.wm_load_mat, bus.addr, bus.wm_data} !== {1'b1, 1'b1, 3'(k), b[k]})
                begin n_fail++; $display("FAIL load_write[%0d]: got %h expected %h", k,
                    {bus.in_ready, bus.wm_load_mat, bus.addr, bus.wm_data}, {1'b1, 1'b1, 3'(k), b[k]}); end
            mem_model[k] = b[k];
        end
    endtask

    // Walks SETTLE+COMPUTE and stops positioned in the first OUTPUT cycle.
    task automatic run_phases(input bit flood);
        for (int c = 0; c <= S + C; c++) begin
            logic exp_clear, exp_en, exp_ov;
            @(negedge clk);
            bus.in_valid = flood ? 1'b1 : 1'($urandom);
            bus.in_data  = 8'($urandom);
            bus.out_ready = 1'($urandom);
            exp_clear = (c == 0);
            exp_en    = (c >= S) && (c < S + C);
            exp_ov    = (c == S + C);
            #1;
            n_checks++;
            if ({bus.mmu_clear, bus.mmu_en, bus.out_valid, bus.in_ready, bus.wm_load_mat, bus.busy, bus.done}
                !== {exp_clear, exp_en, exp_ov, 1'b0, 1'b0, 1'b1, 1'b0})
                begin n_fail++; $display("FAIL phase[%0d]: got %b expected %b", c,
                    {bus.mmu_clear, bus.mmu_en, bus.out_valid, bus.in_ready, bus.wm_load_mat, bus.busy, bus.done},
                    {exp_clear, exp_en, exp_ov, 1'b0, 1'b0, 1'b1, 1'b0}); end
        end
    endtask

    task automatic drain(input int stall_lo, input int stall_hi);
        bit first;
        first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int stall;
            stall = $urandom_range(stall_hi, stall_lo);
            for (int s = 0; s <= stall; s++) begin
                if (!first) @(negedge clk);
                first = 1'b0;
                bus.out_ready = (s == stall);
                bus.in_valid  = 1'($urandom);
                bus.in_data   = 8'($urandom);
                #1;
                n_checks++;
                if ({bus.out_valid, bus.res_sel, bus.out_data, bus.done, bus.busy, bus.in_ready, bus.wm_load_mat}
                    !== {1'b1, 2'(i), 8'(res_base + 8'(i)), 1'b0, 1'b1, 1'b0, 1'b0})
                    begin n_fail++; $display("FAIL out_beat[%0d.%0d]: got %h expected %h", i, s,
                        {bus.out_valid, bus.res_sel, bus.out_data, bus.done, bus.busy, bus.in_ready, bus.wm_load_mat},
                        {1'b1, 2'(i), 8'(res_base + 8'(i)), 1'b0, 1'b1, 1'b0, 1'b0}); end
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        n_checks++;
        if ({bus.done, bus.busy, bus.in_ready, bus.out_valid, bus.mmu_en, bus.addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0})
            begin n_fail++; $display("FAIL done_pulse: got %b", {bus.done, bus.busy, bus.in_ready,
                bus.out_valid, bus.mmu_en, bus.addr}); end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00)
            begin n_fail++; $display("FAIL done_single: got done=%b busy=%b", bus.done, bus.busy); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (mem_dut[k] !== mem_model[k])
                begin n_fail++; $display("FAIL mem[%0d]: got %h expected %h", k, mem_dut[k], mem_model[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [8];
        for (int k = 0; k < 8; k++) b[k] = 8'(k + 1);
        res_base = 8'h10;
        load_job(b, 0, 0);
        run_phases(1'b0);
        drain(0, 0);
    endtask

    task automatic test_gapped();
        logic [7:0] b [8];
        for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
        res_base = 8'($urandom);
        load_job(b, 1, 1);
        run_phases(1'b0);
        drain(0, 1);
    endtask

    task automatic test_output_stall();
        logic [7:0] b [8];
        for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
        res_base = 8'h10;
        load_job(b, 0, 0);
        run_phases(1'b0);
        drain(3, 3);
    endtask

    task automatic test_in_valid_ignored();
        logic [7:0] b [8];
        for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
        res_base = 8'($urandom);
        load_job(b, 0, 2);
        run_phases(1'b1);
        drain(0, 2);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 4; j++) begin
            logic [7:0] b [8];
            for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
            res_base = 8'($urandom);
            load_job(b, 0, 3);
            run_phases(1'($urandom));
            drain(0, 4);
        end
    endtask

    task automatic test_reset_mid_compute();
        logic [7:0] b [8];
        for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
        load_job(b, 0, 0);
        for (int c = 0; c < S + 3; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        #1;
        n_checks++;
        if (bus.mmu_en !== 1'b1)
            begin n_fail++; $display("FAIL pre_reset_en: got %b expected 1", bus.mmu_en); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.mmu_en, bus.mmu_clear, bus.busy, bus.in_ready, bus.addr, bus.out_valid} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0})
            begin n_fail++; $display("FAIL mid_reset: got %b", {bus.mmu_en, bus.mmu_clear, bus.busy,
                bus.in_ready, bus.addr, bus.out_valid}); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
        res_base = 8'($urandom);
        load_job(b, 0, 1);
        run_phases(1'b0);
        drain(0, 1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        res_base      = 8'h10;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_output_stall();
        test_in_valid_ignored();
        test_random_jobs();
        test_reset_mid_compute();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
